// File: rtl/apb4_mem_slave.sv
// APB4 completer fronting a word-organised register-file memory.
// Supports byte-lane write strobes, a fixed number of access-phase wait
// states, and PSLVERR for out-of-range or misaligned addresses.
module apb4_mem_slave #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                    pclk,
    input  logic                    prst_n,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic                    pready,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pslverr
);

    localparam int unsigned NB  = DATA_WIDTH / 8;
    localparam int unsigned LSB = (NB > 1) ? $clog2(NB) : 0;
    localparam int unsigned IW  = ADDR_WIDTH - LSB;
    localparam int unsigned MW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WS  = 4'(WAIT_STATES);

    // The state register records the bus phase observed at the last edge:
    // SETUP means the current cycle is the first access cycle, ACCESS means
    // an earlier access cycle did not complete. This lets pready rise in the
    // very first access cycle while keeping the IDLE/SETUP/ACCESS sequence.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [IW-1:0]   word_idx;
    logic [MW-1:0]   mem_idx;
    logic            misaligned;
    logic            out_of_range;
    logic            acc_err;
    logic            in_access;
    logic            complete;

    assign word_idx     = paddr[ADDR_WIDTH-1:LSB];
    assign mem_idx      = word_idx[MW-1:0];
    assign out_of_range = (32'(word_idx) >= DEPTH);

    generate
        if (LSB > 0) begin : g_align
            assign misaligned = |paddr[LSB-1:0];
        end else begin : g_noalign
            assign misaligned = 1'b0;
        end
    endgenerate

    assign acc_err   = out_of_range | misaligned;
    assign in_access = (state_q == SETUP) || (state_q == ACCESS);
    assign complete  = in_access && psel && penable && (cnt_q == WS);

    // State and wait-counter registers; memory is deliberately not reset.
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and wait-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (psel && !penable) begin
                    state_d = SETUP;
                end
            end
            SETUP, ACCESS: begin
                if (!psel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (penable) begin
                    if (cnt_q == WS) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = ACCESS;
                        cnt_d   = cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Completion response: ready, error flag and read data.
    always_comb begin
        pready  = complete;
        pslverr = complete & acc_err;
        prdata  = '0;
        if (complete && !pwrite && !acc_err) begin
            prdata = mem_q[mem_idx];
        end
    end

    // Byte-lane masked write on an error-free completing write.
    always_ff @(posedge pclk) begin
        if (complete && pwrite && !acc_err) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (pstrb[i]) begin
                    mem_q[mem_idx][8*i +: 8] <= pwdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Directed bench for apb4_mem_slave: three instances with 0, 3 and 2 wait
// states, driven one at a time over separate APB buses.
module tb_apb4_mem_slave;

    localparam int unsigned WS0 = 0;
    localparam int unsigned WS1 = 3;
    localparam int unsigned WS2 = 2;

    logic        pclk;
    logic        prst_n;
    logic        psel_a    [3];
    logic        penable_a [3];
    logic        pwrite_a  [3];
    logic [11:0] paddr_a   [3];
    logic [31:0] pwdata_a  [3];
    logic [3:0]  pstrb_a   [3];
    logic        pready_a  [3];
    logic [31:0] prdata_a  [3];
    logic        pslverr_a [3];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cyc [3];
    int prev;

    apb4_mem_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(WS0)) u_ws0 (
        .pclk(pclk), .prst_n(prst_n), .psel(psel_a[0]), .penable(penable_a[0]),
        .pwrite(pwrite_a[0]), .paddr(paddr_a[0]), .pwdata(pwdata_a[0]), .pstrb(pstrb_a[0]),
        .pready(pready_a[0]), .prdata(prdata_a[0]), .pslverr(pslverr_a[0])
    );

    apb4_mem_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(WS1)) u_ws3 (
        .pclk(pclk), .prst_n(prst_n), .psel(psel_a[1]), .penable(penable_a[1]),
        .pwrite(pwrite_a[1]), .paddr(paddr_a[1]), .pwdata(pwdata_a[1]), .pstrb(pstrb_a[1]),
        .pready(pready_a[1]), .prdata(prdata_a[1]), .pslverr(pslverr_a[1])
    );

    apb4_mem_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(WS2)) u_ws2 (
        .pclk(pclk), .prst_n(prst_n), .psel(psel_a[2]), .penable(penable_a[2]),
        .pwrite(pwrite_a[2]), .paddr(paddr_a[2]), .pwdata(pwdata_a[2]), .pstrb(pstrb_a[2]),
        .pready(pready_a[2]), .prdata(prdata_a[2]), .pslverr(pslverr_a[2])
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic int ws_of(input int k);
        case (k)
            0:       return int'(WS0);
            1:       return int'(WS1);
            default: return int'(WS2);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int k);
        @(posedge pclk); #1;
        psel_a[k]    = 1'b0;
        penable_a[k] = 1'b0;
    endtask

    // Full transfer: setup, then access cycles until pready; ends at the
    // negedge of the completion cycle with the bus still driven.
    task automatic xfer(input int k, input logic wr, input logic [11:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic exp_err, input logic [31:0] exp_rd, input string tag);
        int ws;
        int n;
        int c0;
        ws = ws_of(k);
        @(posedge pclk); #1;
        psel_a[k] = 1'b1; penable_a[k] = 1'b0; pwrite_a[k] = wr;
        paddr_a[k] = a; pwdata_a[k] = d; pstrb_a[k] = s;
        c0 = cyc;
        @(negedge pclk);
        chk({tag, "/setup_rdy"}, 32'(pready_a[k]), 32'd0);
        @(posedge pclk); #1;
        penable_a[k] = 1'b1;
        n = 0;
        @(negedge pclk);
        while (pready_a[k] !== 1'b1 && n <= 20) begin
            chk({tag, "/wait_rdata"}, prdata_a[k], 32'd0);
            chk({tag, "/wait_err"}, 32'(pslverr_a[k]), 32'd0);
            n++;
            @(negedge pclk);
        end
        if (pready_a[k] !== 1'b1) begin
            checks++;
            failures++;
            $error("FAIL %s/timeout observed=no_pready expected=pready", tag);
            return;
        end
        chk({tag, "/waits"}, 32'(n), 32'(ws));
        chk({tag, "/span"}, 32'(cyc - c0 + 1), 32'(2 + ws));
        chk({tag, "/pslverr"}, 32'(pslverr_a[k]), 32'(exp_err));
        chk({tag, "/prdata"}, prdata_a[k], wr ? 32'd0 : exp_rd);
        done_cyc[k] = cyc;
    endtask

    // Setup plus n access cycles; ends at the negedge of the last one.
    task automatic partial(input int k, input logic wr, input logic [11:0] a,
                           input logic [31:0] d, input int n);
        @(posedge pclk); #1;
        psel_a[k] = 1'b1; penable_a[k] = 1'b0; pwrite_a[k] = wr;
        paddr_a[k] = a; pwdata_a[k] = d; pstrb_a[k] = 4'hF;
        for (int i = 0; i < n; i++) begin
            @(posedge pclk); #1;
            penable_a[k] = 1'b1;
            @(negedge pclk);
        end
    endtask

    initial begin
        prst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            psel_a[k] = 1'b0; penable_a[k] = 1'b0; pwrite_a[k] = 1'b0;
            paddr_a[k] = '0; pwdata_a[k] = '0; pstrb_a[k] = '0;
            done_cyc[k] = 0;
        end
        // Bus activity during reset must not produce a response.
        psel_a[0] = 1'b1; penable_a[0] = 1'b1;
        repeat (3) @(negedge pclk);
        for (int k = 0; k < 3; k++) begin
            chk("reset/pready", 32'(pready_a[k]), 32'd0);
            chk("reset/pslverr", 32'(pslverr_a[k]), 32'd0);
            chk("reset/prdata", prdata_a[k], 32'd0);
        end
        @(posedge pclk); #1;
        psel_a[0] = 1'b0; penable_a[0] = 1'b0;
        prst_n = 1'b1;

        // ---------------- zero wait states ----------------
        xfer(0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 1'b0, 32'd0, "w0_full");
        idle(0);
        xfer(0, 1'b0, 12'h010, 32'd0, 4'h0, 1'b0, 32'hDEADBEEF, "r0_full");
        idle(0);
        xfer(0, 1'b1, 12'h010, 32'h11223344, 4'b0101, 1'b0, 32'd0, "w0_strb");
        idle(0);
        xfer(0, 1'b0, 12'h010, 32'd0, 4'h0, 1'b0, 32'hDE22BE44, "r0_strb");
        idle(0);
        xfer(0, 1'b1, 12'h010, 32'hFFFFFFFF, 4'h0, 1'b0, 32'd0, "w0_nostrb");
        idle(0);
        xfer(0, 1'b0, 12'h010, 32'd0, 4'hF, 1'b0, 32'hDE22BE44, "r0_nostrb");
        idle(0);

        // Back-to-back writes then reads, one completion every two cycles.
        xfer(0, 1'b1, 12'h000, 32'h1, 4'hF, 1'b0, 32'd0, "b2b_w0");
        prev = done_cyc[0];
        xfer(0, 1'b1, 12'h004, 32'h2, 4'hF, 1'b0, 32'd0, "b2b_w1");
        chk("b2b_w1/period", 32'(done_cyc[0] - prev), 32'd2);
        prev = done_cyc[0];
        xfer(0, 1'b1, 12'h008, 32'h3, 4'hF, 1'b0, 32'd0, "b2b_w2");
        chk("b2b_w2/period", 32'(done_cyc[0] - prev), 32'd2);
        prev = done_cyc[0];
        xfer(0, 1'b0, 12'h000, 32'd0, 4'h0, 1'b0, 32'h1, "b2b_r0");
        chk("b2b_r0/period", 32'(done_cyc[0] - prev), 32'd2);
        prev = done_cyc[0];
        xfer(0, 1'b0, 12'h004, 32'd0, 4'h0, 1'b0, 32'h2, "b2b_r1");
        chk("b2b_r1/period", 32'(done_cyc[0] - prev), 32'd2);
        prev = done_cyc[0];
        xfer(0, 1'b0, 12'h008, 32'd0, 4'h0, 1'b0, 32'h3, "b2b_r2");
        chk("b2b_r2/period", 32'(done_cyc[0] - prev), 32'd2);
        idle(0);

        // Error responses; 0x400 aliases word 0 in the low index bits.
        xfer(0, 1'b1, 12'h400, 32'hFFFFFFFF, 4'hF, 1'b1, 32'd0, "err_w_range");
        idle(0);
        xfer(0, 1'b0, 12'h000, 32'd0, 4'h0, 1'b0, 32'h1, "err_r_alias");
        idle(0);
        xfer(0, 1'b1, 12'h013, 32'hFFFFFFFF, 4'hF, 1'b1, 32'd0, "err_w_misal");
        idle(0);
        xfer(0, 1'b0, 12'h010, 32'd0, 4'h0, 1'b0, 32'hDE22BE44, "err_r_prior");
        idle(0);
        xfer(0, 1'b0, 12'h400, 32'd0, 4'h0, 1'b1, 32'd0, "err_r_range");
        idle(0);
        xfer(0, 1'b0, 12'h012, 32'd0, 4'h0, 1'b1, 32'd0, "err_r_misal");
        idle(0);

        // Last implemented word.
        xfer(0, 1'b1, 12'h3FC, 32'hCAFEF00D, 4'hF, 1'b0, 32'd0, "w0_top");
        idle(0);
        xfer(0, 1'b0, 12'h3FC, 32'd0, 4'h0, 1'b0, 32'hCAFEF00D, "r0_top");
        idle(0);

        // Access phase without a setup phase is ignored.
        @(posedge pclk); #1;
        psel_a[0] = 1'b1; penable_a[0] = 1'b1; pwrite_a[0] = 1'b0; paddr_a[0] = 12'h010;
        @(negedge pclk);
        chk("noset/pready0", 32'(pready_a[0]), 32'd0);
        @(negedge pclk);
        chk("noset/pready1", 32'(pready_a[0]), 32'd0);
        chk("noset/prdata", prdata_a[0], 32'd0);
        idle(0);

        // ---------------- three wait states ----------------
        xfer(1, 1'b1, 12'h004, 32'h12345678, 4'hF, 1'b0, 32'd0, "w3_full");
        idle(1);
        xfer(1, 1'b0, 12'h004, 32'd0, 4'h0, 1'b0, 32'h12345678, "r3_full");
        idle(1);
        xfer(1, 1'b1, 12'h400, 32'h0, 4'hF, 1'b1, 32'd0, "w3_err");
        idle(1);

        // ---------------- two wait states: abort and reset ----------------
        xfer(2, 1'b1, 12'h020, 32'h5A5A0000, 4'hF, 1'b0, 32'd0, "w2_init");
        idle(2);
        partial(2, 1'b1, 12'h020, 32'hA5A5A5A5, 1);
        chk("abort/pready_acc", 32'(pready_a[2]), 32'd0);
        idle(2);
        @(negedge pclk);
        chk("abort/pready_after", 32'(pready_a[2]), 32'd0);
        xfer(2, 1'b0, 12'h020, 32'd0, 4'h0, 1'b0, 32'h5A5A0000, "abort_rd");
        idle(2);

        // Reset during a completing write: no write takes place.
        partial(2, 1'b1, 12'h020, 32'hA5A5A5A5, 3);
        chk("rstw/pready_pre", 32'(pready_a[2]), 32'd1);
        prst_n = 1'b0;
        #1;
        chk("rstw/pready", 32'(pready_a[2]), 32'd0);
        chk("rstw/pslverr", 32'(pslverr_a[2]), 32'd0);
        chk("rstw/prdata", prdata_a[2], 32'd0);
        @(posedge pclk); #1;
        psel_a[2] = 1'b0; penable_a[2] = 1'b0;
        prst_n = 1'b1;
        xfer(2, 1'b0, 12'h020, 32'd0, 4'h0, 1'b0, 32'h5A5A0000, "rstw_rd");
        idle(2);

        // Reset during a completing read: data drops immediately.
        partial(2, 1'b0, 12'h020, 32'd0, 3);
        chk("rstr/prdata_pre", prdata_a[2], 32'h5A5A0000);
        prst_n = 1'b0;
        #1;
        chk("rstr/pready", 32'(pready_a[2]), 32'd0);
        chk("rstr/prdata", prdata_a[2], 32'd0);
        @(posedge pclk); #1;
        psel_a[2] = 1'b0; penable_a[2] = 1'b0;
        prst_n = 1'b1;
        xfer(2, 1'b1, 12'h020, 32'h13579BDF, 4'hF, 1'b0, 32'd0, "post_rst_w");
        idle(2);
        xfer(2, 1'b0, 12'h020, 32'd0, 4'h0, 1'b0, 32'h13579BDF, "post_rst_r");
        idle(2);

        repeat (2) @(posedge pclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
